// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_pkg -- size encodings, FSM states, alignment check  (rev 1.0)  |
// +--------------------------------------------------------------------+
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // Doubles are only legal when the datapath is 64 bits wide.
   function automatic logic addr_legal(input logic [1:0] size,
                                       input logic [2:0] lo,
                                       input logic       wide);
      case (size)
         SZ_B:    return 1'b1;
         SZ_H:    return ~lo[0];
         SZ_W:    return lo[1:0] == 2'b00;
         default: return wide && (lo == 3'b000);
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_load_align -- load lane extraction and extension  (rev 1.0)    |
// +--------------------------------------------------------------------+
module dmem_load_align
   import dmem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]              word_i,
   input  logic [$clog2(XLEN/8)-1:0]    off_i,
   input  logic [1:0]                   size_i,
   input  logic                         unsigned_i,
   output logic [XLEN-1:0]              data_o
);

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] keep;
   logic            sign;

   assign shifted = word_i >> {off_i, 3'b000};

   always_comb begin
      keep = '1;
      sign = 1'b0;
      case (size_i)
         SZ_B: begin keep = XLEN'(8'hFF);         sign = shifted[7];  end
         SZ_H: begin keep = XLEN'(16'hFFFF);      sign = shifted[15]; end
         SZ_W: begin keep = XLEN'(32'hFFFF_FFFF); sign = shifted[31]; end
         default: ;
      endcase
      data_o = (shifted & keep) | ((sign & ~unsigned_i) ? ~keep : '0);
   end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_lsu -- byte-lane data memory with self-clear, 1-deep LSU (1.0) |
// +--------------------------------------------------------------------+
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [XLEN-1:0]   resp_rdata_o,
   output logic              resp_err_o,
   output logic              init_done_o
);

   localparam int NB    = XLEN / 8;
   localparam int OFFW  = $clog2(NB);
   localparam int IDXW  = ADDR_W - OFFW;
   localparam int WORDS = 2 ** IDXW;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic [XLEN-1:0]   mem_q [WORDS];

   logic [IDXW-1:0]   idx;
   logic [OFFW-1:0]   off;
   logic              legal;
   logic [NB-1:0]     lane_mask;
   logic [NB-1:0]     st_be;
   logic [XLEN-1:0]   st_data;
   logic [XLEN-1:0]   ld_data;
   logic [NB-1:0]     wr_be;
   logic [IDXW-1:0]   wr_idx;
   logic [XLEN-1:0]   wr_data;

   assign idx     = req_addr_i[ADDR_W-1:OFFW];
   assign off     = req_addr_i[OFFW-1:0];
   assign legal   = addr_legal(req_size_i, req_addr_i[2:0], XLEN == 64);
   assign st_be   = lane_mask << off;
   assign st_data = req_wdata_i << {off, 3'b000};

   always_comb begin
      lane_mask = '1;
      case (req_size_i)
         SZ_B:    lane_mask = NB'(4'h1);
         SZ_H:    lane_mask = NB'(4'h3);
         SZ_W:    lane_mask = NB'(4'hF);
         default: lane_mask = '1;
      endcase
   end

   dmem_load_align #(.XLEN(XLEN)) u_load_align (
      .word_i     (mem_q[idx]),
      .off_i      (off),
      .size_i     (req_size_i),
      .unsigned_i (req_unsigned_i),
      .data_o     (ld_data)
   );

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      wr_be        = '0;
      wr_idx       = idx;
      wr_data      = st_data;
      case (state_q)
         ST_CLEAR: begin
            wr_be     = '1;
            wr_idx    = clr_cnt_q;
            wr_data   = '0;
            clr_cnt_d = clr_cnt_q + IDXW'(1);
            if (&clr_cnt_q) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (req_valid_i) begin
               state_d      = ST_RESP;
               resp_err_d   = ~legal;
               resp_rdata_d = (legal && !req_we_i) ? ld_data : '0;
               if (legal && req_we_i) wr_be = st_be;
            end
         end
         ST_RESP: begin
            if (resp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_CLEAR;
         clr_cnt_q    <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Storage carries no reset; the CLEAR sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int l = 0; l < NB; l++) begin
            if (wr_be[l]) mem_q[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
         end
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign resp_valid_o = (state_q == ST_RESP);
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;
   assign init_done_o  = (state_q != ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_lsu -- directed self-checking bench for dmem_lsu  (rev 1.0) |
// +--------------------------------------------------------------------+
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_unsigned, resp_ready;
   logic [1:0]  req_size;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready, resp_valid, resp_err, init_done;
   logic [31:0] resp_rdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmem_lsu #(.XLEN(32), .ADDR_W(12)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_size_i     (req_size),
      .req_unsigned_i (req_unsigned),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .resp_valid_o   (resp_valid),
      .resp_ready_i   (resp_ready),
      .resp_rdata_o   (resp_rdata),
      .resp_err_o     (resp_err),
      .init_done_o    (init_done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check("ready_timeout", 0, 1);
   endtask

   task automatic count_clear(input string tag);
      int n = 0;
      while (!init_done && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, n, 1024);
   endtask

   task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
      wait_ready();
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, "_valid"}, resp_valid, 1);
      check({tag, "_rdata"}, resp_rdata, exp_rd);
      check({tag, "_err"},   resp_err,   exp_err);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_unsigned = 1'b0;
      resp_ready = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready",  req_ready,  0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err",   resp_err,   0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_init_done",  init_done,  0);
      rst = 1'b0;
      count_clear("clear_cycles");
      check("idle_req_ready", req_ready, 1);

      do_req("lw_7fc",  0, 2'd2, 0, 12'h7FC, 0, 32'h0, 0);
      do_req("sw_010",  1, 2'd2, 0, 12'h010, 32'hDEADBEEF, 32'h0, 0);
      do_req("lbu_013", 0, 2'd0, 1, 12'h013, 0, 32'h000000DE, 0);
      do_req("lb_013",  0, 2'd0, 0, 12'h013, 0, 32'hFFFFFFDE, 0);
      do_req("lh_010",  0, 2'd1, 0, 12'h010, 0, 32'hFFFFBEEF, 0);
      do_req("lhu_012", 0, 2'd1, 1, 12'h012, 0, 32'h0000DEAD, 0);
      do_req("lw_010",  0, 2'd2, 0, 12'h010, 0, 32'hDEADBEEF, 0);

      do_req("sh_022",  1, 2'd1, 0, 12'h022, 32'hFFFF1234, 32'h0, 0);
      do_req("lw_020",  0, 2'd2, 0, 12'h020, 0, 32'h12340000, 0);
      do_req("sw_030",  1, 2'd2, 0, 12'h030, 32'hAABBCCDD, 32'h0, 0);
      do_req("sb_031",  1, 2'd0, 0, 12'h031, 32'h1234565A, 32'h0, 0);
      do_req("lw_030",  0, 2'd2, 0, 12'h030, 0, 32'hAABB5ADD, 0);

      do_req("sw_004",  1, 2'd2, 0, 12'h004, 32'h11223344, 32'h0, 0);
      do_req("sw_005",  1, 2'd2, 0, 12'h005, 32'h99999999, 32'h0, 1);
      do_req("lw_004",  0, 2'd2, 0, 12'h004, 0, 32'h11223344, 0);
      do_req("lh_011",  0, 2'd1, 0, 12'h011, 0, 32'h0, 1);
      do_req("lw_012",  0, 2'd2, 0, 12'h012, 0, 32'h0, 1);
      do_req("ld_008",  0, 2'd3, 0, 12'h008, 0, 32'h0, 1);
      do_req("sd_008",  1, 2'd3, 0, 12'h008, 32'h55555555, 32'h0, 1);
      do_req("lw_008",  0, 2'd2, 0, 12'h008, 0, 32'h0, 0);

      // Back-pressure: a competing store is held on the request port throughout.
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 12'h010;
      @(posedge clk); #1;
      req_we = 1'b1; req_addr = 12'h040; req_wdata = 32'hCAFEF00D;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", resp_valid, 1);
         check("stall_rdata", resp_rdata, 32'hDEADBEEF);
         check("stall_err",   resp_err,   0);
         check("stall_ready", req_ready,  0);
         @(posedge clk); #1;
      end
      check("stall_hold_rdata", resp_rdata, 32'hDEADBEEF);
      resp_ready = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("release_ready", req_ready,  1);
      check("release_valid", resp_valid, 0);
      do_req("lw_040", 0, 2'd2, 0, 12'h040, 0, 32'h0, 0);

      // Reset while a response is pending.
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 12'h004;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("pre_rst_valid", resp_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_valid", resp_valid, 0);
      check("mid_rst_init",  init_done,  0);
      check("mid_rst_rdata", resp_rdata, 0);
      rst = 1'b0;
      count_clear("reclear_cycles");
      do_req("lw_010_cleared", 0, 2'd2, 0, 12'h010, 0, 32'h0, 0);
      do_req("lw_004_cleared", 0, 2'd2, 0, 12'h004, 0, 32'h0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 12, byte-address width; memory is 2**ADDR_W bytes.
REQ-003 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-004 clk  in  1  clock, all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  XLEN  store data, taken from the low bytes.
REQ-013 resp_valid  out  1  response present.
REQ-014 resp_ready  in  1  consumer accepts the response.
REQ-015 resp_rdata  out  XLEN  load result, 0 for stores and errors.
REQ-016 resp_err  out  1  request was misaligned or illegal.
REQ-017 init_done  out  1  memory clear complete.

Function
REQ-018 Storage SHALL be 2**ADDR_W/(XLEN/8) words of XLEN/8 byte lanes, with per-lane write enables.
REQ-019 The FSM SHALL have states CLEAR, IDLE and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-020 CLEAR SHALL zero one word per cycle from index 0 to the last index, then enter IDLE and set init_done=1.
REQ-021 The block SHALL accept a request on a cycle where req_valid and req_ready are both 1, then move to RESP.
REQ-022 Alignment SHALL be checked as follows: byte is always legal; half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0 and XLEN=64; size 3 with XLEN=32 is illegal.
REQ-023 On an error, no lane SHALL be written, resp_err SHALL be 1 and resp_rdata SHALL be 0.
REQ-024 A legal store SHALL write the selected lanes on the accept edge, using req_wdata bytes shifted to the address lane offset.
REQ-025 A legal load SHALL read on the accept edge, shift the lanes down by the address offset, extend per req_unsigned, and register the result into resp_rdata.
REQ-026 resp_valid SHALL rise the cycle after accept, giving a latency of exactly 1 cycle.
REQ-027 resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-028 No new request SHALL be accepted while in RESP, so at most one request is outstanding and peak throughput is 1 request per 2 cycles.
REQ-029 A load that follows a store to the same address SHALL return the stored data.
REQ-030 Address arithmetic SHALL use the word index addr[ADDR_W-1:log2(XLEN/8)] with no wrap across words, since aligned accesses never cross a word.

Reset
REQ-031 On rst the block SHALL set state=CLEAR, the clear counter to 0, and outputs to req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, init_done=0.
REQ-032 rst asserted mid-response or mid-clear SHALL drop any pending response and restart CLEAR from index 0.
REQ-033 Memory contents SHALL be all zero once init_done=1.

Structure
REQ-034 Package dmem_pkg SHALL hold the size encoding constants SZ_B, SZ_H, SZ_W, SZ_D and the FSM state enum.
REQ-035 Lane extraction and extension SHALL be placed in combinational sub-module dmem_load_align, which is shared with future cache fill paths.
REQ-036 The top level SHALL contain only the FSM, clear counter, storage array and store lane steering.

Verification
REQ-037 Reset then idle: init_done=0 for exactly 1024 cycles (XLEN=32, ADDR_W=12), then req_ready=1, and a load of word 0x7FC returns 0.
REQ-038 Store word 0xDEADBEEF @0x010, then lbu @0x013 returns 0x000000DE, lb @0x013 returns 0xFFFFFFDE, and lh @0x010 returns 0xFFFFBEEF.
REQ-039 Store half 0x1234 @0x022: a word load @0x020 returns 0x12340000, and lanes 0-1 remain unchanged.
REQ-040 Misaligned sw @0x005 returns resp_err=1 and rdata=0, and a later word load @0x004 still returns its prior value; size 3 with XLEN=32 also returns resp_err=1.
REQ-041 With resp_ready held 0 for 5 cycles, the response stays stable and req_ready=0; resp_ready=1 gives IDLE the next cycle.
REQ-042 rst pulsed while in RESP gives resp_valid=0 the next cycle, init_done=0, and a full clear rerun.
